ysyx_25010008_axi4_sram_slave: RTL and testbench
================================================

Name: ysyx_25010008_axi4_sram_slave

Overview:
- AXI4 responder (slave) backed by a word-addressed internal memory array.
- It is the other end of the CPU's io_master AXI4 interface: it accepts AR/AW/W requests and returns R/B responses.
- Used as the simulation memory and for bus-protocol verification.
- Read and write channels run independent FSMs; INCR and FIXED bursts are supported.

Parameters:
ADDR_BASE, 32'h8000_0000, byte address of word 0
DEPTH_WORDS, 4096, number of 32-bit words (power of two)
RD_LATENCY, 1, cycles from AR handshake to first rvalid (min 1)

Ports:
clock  in  1  system clock
reset  in  1  synchronous active-high reset
awready out 1 / awvalid in 1 / awid in 4 / awaddr in 32 / awlen in 8 / awsize in 3 / awburst in 2  AW channel
wready out 1 / wvalid in 1 / wdata in 32 / wstrb in 4 / wlast in 1  W channel
bready in 1 / bvalid out 1 / bid out 4 / bresp out 2  B channel
arready out 1 / arvalid in 1 / arid in 4 / araddr in 32 / arlen in 8 / arsize in 3 / arburst in 2  AR channel
rready in 1 / rvalid out 1 / rid out 4 / rdata out 32 / rresp out 2 / rlast out 1  R channel

Behaviour:
- Reset:
  - awready=1, arready=1; wready, bvalid, rvalid, rlast=0; bid, rid, bresp, rresp, rdata=0.
  - Both FSMs go to IDLE.
  - Memory contents are not cleared.
  - Reset mid-burst aborts the burst immediately; no further beats or responses.
- Read FSM R_IDLE -> R_WAIT -> R_DATA -> R_IDLE:
  - R_IDLE: arready=1. On arvalid&arready, latch id, addr, len, size, burst and the error flag; clear the beat counter; load the wait counter with RD_LATENCY-1. arready drops the next cycle.
  - R_WAIT: counts down; moves to R_DATA when the counter reaches 0. With RD_LATENCY=1, rvalid rises the cycle after the AR handshake.
  - R_DATA: rvalid=1. rdata = mem[word index]; rid = latched id; rlast = (beat==len). rdata, rid, rresp and rlast hold stable while rvalid&!rready.
  - On rready: INCR advances addr by (1<<size); FIXED keeps addr; beat is incremented.
  - The rlast beat handshake returns to R_IDLE, and arready=1 the following cycle.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: awready=1. On AW handshake, latch the fields; wready=1 from the next cycle.
  - W_DATA: each wvalid&wready writes the bytes selected by wstrb at the current word (byte lane i <- wdata[8i+7:8i]); address advances as for reads.
  - A beat with wlast=1 moves to W_RESP. If wlast arrives at beat!=len, or is absent at beat==len, the burst still ends at wlast, with bresp=SLVERR.
  - W_RESP: bvalid=1, bid = latched id. On bready, return to W_IDLE.
- Errors:
  - Decided at address latch: addr outside [ADDR_BASE, ADDR_BASE+4*DEPTH_WORDS), or size>2, or burst==WRAP(2'b10).
  - Out-of-range address gives DECERR (2'b11); bad size or burst gives SLVERR (2'b10). DECERR takes priority.
  - An error burst still runs its full beat count. Reads return rdata=0; writes are suppressed. rresp or bresp carries the error on every beat or on the response.
  - An address that walks out of range mid-burst gives DECERR from that beat onward.
- Width and alignment:
  - Word index = (addr-ADDR_BASE)>>2, truncated to log2(DEPTH_WORDS) bits.
  - Narrow reads return the full aligned word; the master selects lanes.
  - Address arithmetic is 32-bit with wrap.
- Simultaneous events:
  - A write beat and a read beat to the same word in the same cycle: the read returns the old data, and the write commits at the clock edge.
  - AR and AW handshakes may occur in the same cycle; the channels are independent.

Optional Feature:
- Macro: YSYX_25010008_SRAM_RAND_DELAY_EN
- When defined: a 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 on reset) steps every cycle. arready, awready and wready are ANDed with lfsr[0], and rvalid and bvalid are withheld while lfsr[1]==0. Channel stability rules still hold: once rvalid or bvalid is raised, it is not dropped until the handshake.
- When undefined: no LFSR; timing is exactly as described in Behaviour.

Test Plan:
- Single read: after writing mem[0]=32'hDEADBEEF, araddr=8000_0000, arlen=0, arsize=2, arid=3 -> rvalid one cycle after the handshake, with rdata=DEADBEEF, rid=3, rresp=0, rlast=1.
- INCR burst: write 4 beats 1,2,3,4 at 8000_0010 (awlen=3) -> bresp=0 after the wlast beat; read back with arlen=3 -> 1,2,3,4, with rlast only on beat 4. Hold rready=0 for 3 cycles on beat 2 -> data stays stable.
- Byte strobe: mem[1]=32'h11223344, write wdata=AABBCCDD, wstrb=4'b0101 to 8000_0004 -> readback 32'h11BB33DD.
- Errors: araddr=7FFF_FFFC -> rresp=2'b11, rdata=0. arburst=WRAP -> rresp=2'b10. awlen=1 with wlast on beat 0 -> bresp=2'b10, second word unchanged.
- Concurrency: an AR and an AW to the same word in the same cycle, with the write beat coinciding with the read beat -> R returns old data, and a subsequent read returns new data.
- Reset mid-burst: assert reset during beat 2 of an arlen=7 read -> next cycle rvalid=0, arready=1, and a new read completes normally.

Source files
------------

// File: rtl/ysyx_25010008_axi4_sram_slave_if.sv
// AXI4 bus bundle between a master (CPU io_master or a testbench) and the
// SRAM responder. The slave modport is the responder's view.
interface ysyx_25010008_axi4_sram_slave_if;
  // AW channel
  logic        awready;
  logic        awvalid;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  // W channel
  logic        wready;
  logic        wvalid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  // B channel
  logic        bready;
  logic        bvalid;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  // AR channel
  logic        arready;
  logic        arvalid;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  // R channel
  logic        rready;
  logic        rvalid;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;

  modport slave (
    output awready, input awvalid, awid, awaddr, awlen, awsize, awburst,
    output wready,  input wvalid, wdata, wstrb, wlast,
    input  bready,  output bvalid, bid, bresp,
    output arready, input arvalid, arid, araddr, arlen, arsize, arburst,
    input  rready,  output rvalid, rid, rdata, rresp, rlast
  );

  modport master (
    input  awready, output awvalid, awid, awaddr, awlen, awsize, awburst,
    input  wready,  output wvalid, wdata, wstrb, wlast,
    output bready,  input bvalid, bid, bresp,
    input  arready, output arvalid, arid, araddr, arlen, arsize, arburst,
    output rready,  input rvalid, rid, rdata, rresp, rlast
  );
endinterface

// File: rtl/ysyx_25010008_axi4_sram_slave.sv
// AXI4 responder backed by a word-addressed 32-bit memory array.
// Independent read and write FSMs; INCR and FIXED bursts. Out-of-range
// addresses answer DECERR, bad size / WRAP bursts answer SLVERR.
// Optional macro YSYX_25010008_SRAM_RAND_DELAY_EN inserts LFSR-driven
// backpressure on the ready signals and withholds fresh rvalid/bvalid.
module ysyx_25010008_axi4_sram_slave #(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned RD_LATENCY  = 1
) (
  input  logic                           clock,
  input  logic                           reset,
  ysyx_25010008_axi4_sram_slave_if.slave s_axi
);
  localparam int unsigned IDX_W       = $clog2(DEPTH_WORDS);
  localparam logic [31:0] MEM_BYTES   = 32'(DEPTH_WORDS * 4);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [1:0]  RESP_DECERR = 2'b11;
  localparam logic [1:0]  BURST_FIXED = 2'b00;
  localparam logic [1:0]  BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_DATA = 2'd2} rd_state_e;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wr_state_e;

  // Offset computed with 32-bit wrap, so addresses below the base land high.
  function automatic logic f_out_of_range(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - ADDR_BASE;
    return (off >= MEM_BYTES);
  endfunction

  function automatic logic f_bad_attr(input logic [2:0] size, input logic [1:0] burst);
    return (size > 3'd2) || (burst == BURST_WRAP);
  endfunction

  // FIXED holds the address; anything else steps by the beat size.
  function automatic logic [31:0] f_next_addr(input logic [31:0] addr, input logic [2:0] size,
                                              input logic [1:0] burst);
    if (burst == BURST_FIXED) return addr;
    else                      return addr + (32'd1 << size);
  endfunction

  // DECERR outranks SLVERR.
  function automatic logic [1:0] f_resp(input logic dec, input logic slv);
    if (dec)      return RESP_DECERR;
    else if (slv) return RESP_SLVERR;
    else          return RESP_OKAY;
  endfunction

  function automatic logic [IDX_W-1:0] f_word_idx(input logic [31:0] addr);
    return IDX_W'((addr - ADDR_BASE) >> 2);
  endfunction

  logic [31:0] r_mem [DEPTH_WORDS];

  // Read channel state
  rd_state_e   r_rstate;
  logic [3:0]  r_ar_id;
  logic [31:0] r_ar_addr;
  logic [7:0]  r_ar_len;
  logic [2:0]  r_ar_size;
  logic [1:0]  r_ar_burst;
  logic        r_ar_slv;
  logic        r_ar_dec;
  logic [7:0]  r_rbeat;
  logic [15:0] r_rwait;
  logic        r_arready;
  logic        r_rvalid;
  logic [3:0]  r_rid;
  logic [31:0] r_rdata;
  logic [1:0]  r_rresp;
  logic        r_rlast;

  // Write channel state
  wr_state_e   r_wstate;
  logic [3:0]  r_aw_id;
  logic [31:0] r_aw_addr;
  logic [7:0]  r_aw_len;
  logic [2:0]  r_aw_size;
  logic [1:0]  r_aw_burst;
  logic        r_aw_slv;
  logic        r_aw_dec;
  logic [7:0]  r_wbeat;
  logic        r_w_lenerr;
  logic        r_awready;
  logic        r_wready;
  logic        r_bvalid;
  logic [3:0]  r_bid;
  logic [1:0]  r_bresp;

  // Effective (possibly throttled) handshake signals
  logic w_arready, w_awready, w_wready, w_rvalid, w_bvalid;
  logic w_ar_hs, w_r_hs, w_aw_hs, w_w_hs, w_b_hs;

  assign w_ar_hs = s_axi.arvalid & w_arready;
  assign w_r_hs  = w_rvalid & s_axi.rready;
  assign w_aw_hs = s_axi.awvalid & w_awready;
  assign w_w_hs  = s_axi.wvalid & w_wready;
  assign w_b_hs  = w_bvalid & s_axi.bready;

`ifdef YSYX_25010008_SRAM_RAND_DELAY_EN
  logic [15:0] r_lfsr;
  logic        r_rvalid_shown;
  logic        r_bvalid_shown;

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1 stepping every cycle.
  always_ff @(posedge clock) begin
    if (reset) r_lfsr <= 16'hACE1;
    else       r_lfsr <= {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
  end

  // Remember a valid already exposed to the master so it is never retracted.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rvalid_shown <= 1'b0;
      r_bvalid_shown <= 1'b0;
    end else begin
      r_rvalid_shown <= w_rvalid & ~s_axi.rready;
      r_bvalid_shown <= w_bvalid & ~s_axi.bready;
    end
  end

  assign w_arready = r_arready & r_lfsr[0];
  assign w_awready = r_awready & r_lfsr[0];
  assign w_wready  = r_wready  & r_lfsr[0];
  assign w_rvalid  = r_rvalid & (r_rvalid_shown | r_lfsr[1]);
  assign w_bvalid  = r_bvalid & (r_bvalid_shown | r_lfsr[1]);
`else
  assign w_arready = r_arready;
  assign w_awready = r_awready;
  assign w_wready  = r_wready;
  assign w_rvalid  = r_rvalid;
  assign w_bvalid  = r_bvalid;
`endif

  assign s_axi.arready = w_arready;
  assign s_axi.awready = w_awready;
  assign s_axi.wready  = w_wready;
  assign s_axi.rvalid  = w_rvalid;
  assign s_axi.rid     = r_rid;
  assign s_axi.rdata   = r_rdata;
  assign s_axi.rresp   = r_rresp;
  assign s_axi.rlast   = r_rlast;
  assign s_axi.bvalid  = w_bvalid;
  assign s_axi.bid     = r_bid;
  assign s_axi.bresp   = r_bresp;

  // Read-side address bookkeeping
  logic [31:0] w_ar_next_addr;
  logic        w_ar_next_dec;
  logic        w_ar_in_dec;
  logic        w_ar_in_slv;
  logic [31:0] w_rd_addr;
  logic        w_rd_err;
  logic [31:0] w_rd_word;

  assign w_ar_next_addr = f_next_addr(r_ar_addr, r_ar_size, r_ar_burst);
  assign w_ar_next_dec  = r_ar_dec | f_out_of_range(w_ar_next_addr);
  assign w_ar_in_dec    = f_out_of_range(s_axi.araddr);
  assign w_ar_in_slv    = f_bad_attr(s_axi.arsize, s_axi.arburst);

  // Pick the address whose word is loaded into rdata at the next edge.
  always_comb begin
    w_rd_addr = r_ar_addr;
    w_rd_err  = r_ar_dec | r_ar_slv;
    case (r_rstate)
      R_IDLE: begin
        w_rd_addr = s_axi.araddr;
        w_rd_err  = w_ar_in_dec | w_ar_in_slv;
      end
      R_DATA: begin
        w_rd_addr = w_ar_next_addr;
        w_rd_err  = w_ar_next_dec | r_ar_slv;
      end
      default: begin
        w_rd_addr = r_ar_addr;
        w_rd_err  = r_ar_dec | r_ar_slv;
      end
    endcase
  end

  assign w_rd_word = w_rd_err ? 32'd0 : r_mem[f_word_idx(w_rd_addr)];

  // Read FSM: accept AR, wait RD_LATENCY, stream beats with registered R outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rstate   <= R_IDLE;
      r_ar_id    <= 4'd0;
      r_ar_addr  <= 32'd0;
      r_ar_len   <= 8'd0;
      r_ar_size  <= 3'd0;
      r_ar_burst <= 2'd0;
      r_ar_slv   <= 1'b0;
      r_ar_dec   <= 1'b0;
      r_rbeat    <= 8'd0;
      r_rwait    <= 16'd0;
      r_arready  <= 1'b1;
      r_rvalid   <= 1'b0;
      r_rid      <= 4'd0;
      r_rdata    <= 32'd0;
      r_rresp    <= 2'd0;
      r_rlast    <= 1'b0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (w_ar_hs) begin
            r_ar_id    <= s_axi.arid;
            r_ar_addr  <= s_axi.araddr;
            r_ar_len   <= s_axi.arlen;
            r_ar_size  <= s_axi.arsize;
            r_ar_burst <= s_axi.arburst;
            r_ar_slv   <= w_ar_in_slv;
            r_ar_dec   <= w_ar_in_dec;
            r_rbeat    <= 8'd0;
            r_rwait    <= 16'(RD_LATENCY - 32'd1);
            r_arready  <= 1'b0;
            if (RD_LATENCY <= 32'd1) begin
              r_rstate <= R_DATA;
              r_rvalid <= 1'b1;
              r_rid    <= s_axi.arid;
              r_rdata  <= w_rd_word;
              r_rresp  <= f_resp(w_ar_in_dec, w_ar_in_slv);
              r_rlast  <= (s_axi.arlen == 8'd0);
            end else begin
              r_rstate <= R_WAIT;
            end
          end
        end
        R_WAIT: begin
          if (r_rwait <= 16'd1) begin
            r_rstate <= R_DATA;
            r_rvalid <= 1'b1;
            r_rid    <= r_ar_id;
            r_rdata  <= w_rd_word;
            r_rresp  <= f_resp(r_ar_dec, r_ar_slv);
            r_rlast  <= (r_ar_len == 8'd0);
          end else begin
            r_rwait <= r_rwait - 16'd1;
          end
        end
        R_DATA: begin
          if (w_r_hs) begin
            if (r_rlast) begin
              r_rstate  <= R_IDLE;
              r_rvalid  <= 1'b0;
              r_rlast   <= 1'b0;
              r_arready <= 1'b1;
            end else begin
              r_ar_addr <= w_ar_next_addr;
              r_ar_dec  <= w_ar_next_dec;
              r_rbeat   <= r_rbeat + 8'd1;
              r_rdata   <= w_rd_word;
              r_rresp   <= f_resp(w_ar_next_dec, r_ar_slv);
              r_rlast   <= ((r_rbeat + 8'd1) == r_ar_len);
            end
          end
        end
        default: begin
          r_rstate  <= R_IDLE;
          r_rvalid  <= 1'b0;
          r_rlast   <= 1'b0;
          r_arready <= 1'b1;
        end
      endcase
    end
  end

  // Write-side bookkeeping
  logic [31:0]      w_aw_next_addr;
  logic             w_aw_next_dec;
  logic             w_aw_in_dec;
  logic             w_aw_in_slv;
  logic             w_w_beat_lenerr;
  logic             w_mem_we;
  logic [IDX_W-1:0] w_wr_idx;

  assign w_aw_next_addr  = f_next_addr(r_aw_addr, r_aw_size, r_aw_burst);
  assign w_aw_next_dec   = r_aw_dec | f_out_of_range(w_aw_next_addr);
  assign w_aw_in_dec     = f_out_of_range(s_axi.awaddr);
  assign w_aw_in_slv     = f_bad_attr(s_axi.awsize, s_axi.awburst);
  // wlast early, or the final beat arriving without wlast
  assign w_w_beat_lenerr = s_axi.wlast ? (r_wbeat != r_aw_len) : (r_wbeat == r_aw_len);
  assign w_mem_we        = (r_wstate == W_DATA) & w_w_hs & ~(r_aw_dec | r_aw_slv) & ~reset;
  assign w_wr_idx        = f_word_idx(r_aw_addr);

  // Write FSM: accept AW, absorb W beats until wlast, then hold B until accepted.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wstate   <= W_IDLE;
      r_aw_id    <= 4'd0;
      r_aw_addr  <= 32'd0;
      r_aw_len   <= 8'd0;
      r_aw_size  <= 3'd0;
      r_aw_burst <= 2'd0;
      r_aw_slv   <= 1'b0;
      r_aw_dec   <= 1'b0;
      r_wbeat    <= 8'd0;
      r_w_lenerr <= 1'b0;
      r_awready  <= 1'b1;
      r_wready   <= 1'b0;
      r_bvalid   <= 1'b0;
      r_bid      <= 4'd0;
      r_bresp    <= 2'd0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (w_aw_hs) begin
            r_aw_id    <= s_axi.awid;
            r_aw_addr  <= s_axi.awaddr;
            r_aw_len   <= s_axi.awlen;
            r_aw_size  <= s_axi.awsize;
            r_aw_burst <= s_axi.awburst;
            r_aw_slv   <= w_aw_in_slv;
            r_aw_dec   <= w_aw_in_dec;
            r_wbeat    <= 8'd0;
            r_w_lenerr <= 1'b0;
            r_awready  <= 1'b0;
            r_wready   <= 1'b1;
            r_wstate   <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_w_hs) begin
            if (s_axi.wlast) begin
              r_wstate <= W_RESP;
              r_wready <= 1'b0;
              r_bvalid <= 1'b1;
              r_bid    <= r_aw_id;
              r_bresp  <= f_resp(r_aw_dec, r_aw_slv | r_w_lenerr | w_w_beat_lenerr);
            end else begin
              r_aw_addr  <= w_aw_next_addr;
              r_aw_dec   <= w_aw_next_dec;
              r_wbeat    <= r_wbeat + 8'd1;
              r_w_lenerr <= r_w_lenerr | w_w_beat_lenerr;
            end
          end
        end
        W_RESP: begin
          if (w_b_hs) begin
            r_wstate  <= W_IDLE;
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
          end
        end
        default: begin
          r_wstate  <= W_IDLE;
          r_wready  <= 1'b0;
          r_bvalid  <= 1'b0;
          r_awready <= 1'b1;
        end
      endcase
    end
  end

  // Commit the strobed byte lanes of an accepted, error-free write beat.
  always_ff @(posedge clock) begin
    if (w_mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (s_axi.wstrb[i]) r_mem[w_wr_idx][8*i +: 8] <= s_axi.wdata[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_ysyx_25010008_axi4_sram_slave.sv
// Scoreboard bench for the AXI4 SRAM responder: expected R beats and B
// responses are queued when a request is issued and compared on arrival.
module tb_ysyx_25010008_axi4_sram_slave;
  localparam logic [31:0] BASE = 32'h8000_0000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ysyx_25010008_axi4_sram_slave_if bus ();

  ysyx_25010008_axi4_sram_slave dut (
    .clock (clk),
    .reset (reset),
    .s_axi (bus)
  );

  typedef struct {
    logic [31:0] data;
    logic [3:0]  id;
    logic [1:0]  resp;
    logic        last;
  } rbeat_t;

  typedef struct {
    logic [3:0] id;
    logic [1:0] resp;
  } bexp_t;

  rbeat_t      rq[$];
  bexp_t       bq[$];
  logic [31:0] mdl [4096];
  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  int          n_checks = 0;
  int          n_errs   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic oor(input logic [31:0] a);
    return (a < BASE) || (a >= BASE + 32'd16384);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'(((a - BASE) >> 2) & 32'h0000_0FFF);
  endfunction

  function automatic logic [31:0] adv(input logic [31:0] a, input logic [2:0] size, input logic [1:0] burst);
    return (burst == 2'b00) ? a : a + (32'd1 << size);
  endfunction

  task automatic push_read_exp(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                               input logic [1:0] burst, input logic [3:0] id);
    logic        dec;
    logic        bad;
    logic [31:0] a;
    rbeat_t      e;
    dec = 1'b0;
    bad = (size > 3'd2) || (burst == 2'b10);
    a   = addr;
    for (int b = 0; b <= int'(len); b++) begin
      dec    = dec | oor(a);
      e.resp = dec ? 2'b11 : (bad ? 2'b10 : 2'b00);
      e.data = (e.resp != 2'b00) ? 32'd0 : mdl[widx(a)];
      e.id   = id;
      e.last = (b == int'(len));
      rq.push_back(e);
      a = adv(a, size, burst);
    end
  endtask

  // Issue AR, then collect len+1 beats; optionally stall rready on one beat.
  task automatic do_read(input string tag, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input logic [3:0] id,
                         input int stall_beat, input int stall_cyc, input bit check_lat);
    int     n;
    rbeat_t e;
    push_read_exp(addr, len, size, burst, id);
    bus.araddr = addr; bus.arlen = len; bus.arsize = size; bus.arburst = burst; bus.arid = id;
    bus.arvalid = 1'b1;
    n = 0;
    while (!bus.arready && n < 50) begin @(posedge clk); #1; n++; end
    if (!bus.arready) begin
      check_eq({tag, "_ar_timeout"}, 32'd0, 32'd1);
      bus.arvalid = 1'b0; rq.delete(); return;
    end
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    if (check_lat) begin
      check_eq({tag, "_latency_rvalid"}, {31'd0, bus.rvalid}, 32'd1);
      check_eq({tag, "_arready_low"}, {31'd0, bus.arready}, 32'd0);
    end
    for (int b = 0; b <= int'(len); b++) begin
      n = 0;
      while (!bus.rvalid && n < 50) begin @(posedge clk); #1; n++; end
      if (!bus.rvalid) begin
        check_eq({tag, "_r_timeout"}, 32'd0, 32'd1);
        rq.delete(); return;
      end
      e = rq.pop_front();
      check_eq({tag, "_rdata"}, bus.rdata, e.data);
      check_eq({tag, "_rid"},   {28'd0, bus.rid}, {28'd0, e.id});
      check_eq({tag, "_rresp"}, {30'd0, bus.rresp}, {30'd0, e.resp});
      check_eq({tag, "_rlast"}, {31'd0, bus.rlast}, {31'd0, e.last});
      if (b == stall_beat) begin
        for (int c = 0; c < stall_cyc; c++) begin
          @(posedge clk); #1;
          check_eq({tag, "_stall_rvalid"}, {31'd0, bus.rvalid}, 32'd1);
          check_eq({tag, "_stall_rdata"}, bus.rdata, e.data);
          check_eq({tag, "_stall_rlast"}, {31'd0, bus.rlast}, {31'd0, e.last});
        end
      end
      bus.rready = 1'b1;
      @(posedge clk); #1;
      bus.rready = 1'b0;
    end
    check_eq({tag, "_arready_back"}, {31'd0, bus.arready}, 32'd1);
  endtask

  // Issue AW, send nbeats W beats from wd/ws (wlast on the final one), collect B.
  task automatic do_write(input string tag, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input logic [3:0] id,
                          input int nbeats);
    logic        dec;
    logic        bad;
    logic [31:0] a;
    bexp_t       be;
    bexp_t       got;
    int          n;
    dec = 1'b0;
    bad = (size > 3'd2) || (burst == 2'b10);
    a   = addr;
    for (int b = 0; b < nbeats; b++) begin
      dec = dec | oor(a);
      if (!dec && !bad) begin
        for (int i = 0; i < 4; i++) if (ws[b][i]) mdl[widx(a)][8*i +: 8] = wd[b][8*i +: 8];
      end
      a = adv(a, size, burst);
    end
    be.id   = id;
    be.resp = dec ? 2'b11 : ((bad || (nbeats != int'(len) + 1)) ? 2'b10 : 2'b00);
    bq.push_back(be);

    bus.awaddr = addr; bus.awlen = len; bus.awsize = size; bus.awburst = burst; bus.awid = id;
    bus.awvalid = 1'b1;
    n = 0;
    while (!bus.awready && n < 50) begin @(posedge clk); #1; n++; end
    if (!bus.awready) begin
      check_eq({tag, "_aw_timeout"}, 32'd0, 32'd1);
      bus.awvalid = 1'b0; bq.delete(); return;
    end
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      bus.wvalid = 1'b1; bus.wdata = wd[b]; bus.wstrb = ws[b]; bus.wlast = (b == nbeats - 1);
      n = 0;
      while (!bus.wready && n < 50) begin @(posedge clk); #1; n++; end
      if (!bus.wready) begin
        check_eq({tag, "_w_timeout"}, 32'd0, 32'd1);
        bus.wvalid = 1'b0; bus.wlast = 1'b0; bq.delete(); return;
      end
      @(posedge clk); #1;
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    n = 0;
    while (!bus.bvalid && n < 50) begin @(posedge clk); #1; n++; end
    if (!bus.bvalid) begin
      check_eq({tag, "_b_timeout"}, 32'd0, 32'd1);
      bq.delete(); return;
    end
    got = bq.pop_front();
    check_eq({tag, "_bid"},   {28'd0, bus.bid}, {28'd0, got.id});
    check_eq({tag, "_bresp"}, {30'd0, bus.bresp}, {30'd0, got.resp});
    bus.bready = 1'b1;
    @(posedge clk); #1;
    bus.bready = 1'b0;
    check_eq({tag, "_awready_back"}, {31'd0, bus.awready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rbeat_t e;
    bexp_t  be;
    bus.awvalid = 1'b0; bus.awid = 4'd0; bus.awaddr = 32'd0; bus.awlen = 8'd0;
    bus.awsize = 3'd0; bus.awburst = 2'd0;
    bus.wvalid = 1'b0; bus.wdata = 32'd0; bus.wstrb = 4'd0; bus.wlast = 1'b0;
    bus.bready = 1'b0;
    bus.arvalid = 1'b0; bus.arid = 4'd0; bus.araddr = 32'd0; bus.arlen = 8'd0;
    bus.arsize = 3'd0; bus.arburst = 2'd0;
    bus.rready = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    check_eq("rst_awready", {31'd0, bus.awready}, 32'd1);
    check_eq("rst_arready", {31'd0, bus.arready}, 32'd1);
    check_eq("rst_wready",  {31'd0, bus.wready},  32'd0);
    check_eq("rst_bvalid",  {31'd0, bus.bvalid},  32'd0);
    check_eq("rst_rvalid",  {31'd0, bus.rvalid},  32'd0);
    check_eq("rst_rlast",   {31'd0, bus.rlast},   32'd0);
    check_eq("rst_rdata",   bus.rdata, 32'd0);
    check_eq("rst_rid",     {28'd0, bus.rid}, 32'd0);
    check_eq("rst_bresp",   {30'd0, bus.bresp}, 32'd0);

    // Single write + read with latency check
    wd[0] = 32'hDEAD_BEEF; ws[0] = 4'hF;
    do_write("w_single", BASE, 8'd0, 3'd2, 2'b01, 4'd1, 1);
    do_read("r_single", BASE, 8'd0, 3'd2, 2'b01, 4'd3, -1, 0, 1'b1);

    // INCR 4-beat write, readback with a 3-cycle stall on beat 2
    for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
    do_write("w_incr", BASE + 32'h10, 8'd3, 3'd2, 2'b01, 4'd2, 4);
    do_read("r_incr", BASE + 32'h10, 8'd3, 3'd2, 2'b01, 4'd4, 1, 3, 1'b0);

    // FIXED burst repeats the same word
    do_read("r_fixed", BASE + 32'h10, 8'd2, 3'd2, 2'b00, 4'd7, -1, 0, 1'b0);

    // Byte strobes
    wd[0] = 32'h1122_3344; ws[0] = 4'hF;
    do_write("w_strb_init", BASE + 32'h4, 8'd0, 3'd2, 2'b01, 4'd0, 1);
    wd[0] = 32'hAABB_CCDD; ws[0] = 4'b0101;
    do_write("w_strb", BASE + 32'h4, 8'd0, 3'd2, 2'b01, 4'd0, 1);
    do_read("r_strb", BASE + 32'h4, 8'd0, 3'd2, 2'b01, 4'd0, -1, 0, 1'b0);

    // Errors
    do_read("r_decerr", 32'h7FFF_FFFC, 8'd0, 3'd2, 2'b01, 4'd1, -1, 0, 1'b0);
    do_read("r_wrap", BASE, 8'd0, 3'd2, 2'b10, 4'd2, -1, 0, 1'b0);
    do_read("r_size", BASE, 8'd0, 3'd3, 2'b01, 4'd3, -1, 0, 1'b0);
    do_read("r_walkout", BASE + 32'h3FFC, 8'd1, 3'd2, 2'b01, 4'd4, -1, 0, 1'b0);
    wd[0] = 32'hAAAA_0000; wd[1] = 32'hBBBB_1111; ws[0] = 4'hF; ws[1] = 4'hF;
    do_write("w_pair", BASE + 32'h20, 8'd1, 3'd2, 2'b01, 4'd5, 2);
    wd[0] = 32'hCCCC_2222;
    do_write("w_early_last", BASE + 32'h20, 8'd1, 3'd2, 2'b01, 4'd6, 1);
    do_read("r_early_last", BASE + 32'h20, 8'd1, 3'd2, 2'b01, 4'd6, -1, 0, 1'b0);
    wd[0] = 32'h0BAD_0BAD;
    do_write("w_decerr", BASE + 32'h4000, 8'd0, 3'd2, 2'b01, 4'd8, 1);

    // Concurrent AR + AW to the same word, write beat coincides with read beat
    wd[0] = 32'h1234_5678; ws[0] = 4'hF;
    do_write("w_cc_init", BASE + 32'h40, 8'd0, 3'd2, 2'b01, 4'd0, 1);
    push_read_exp(BASE + 32'h40, 8'd0, 3'd2, 2'b01, 4'd5);
    mdl[16] = 32'hCAFE_F00D;
    be.id = 4'd6; be.resp = 2'b00; bq.push_back(be);
    bus.araddr = BASE + 32'h40; bus.arlen = 8'd0; bus.arsize = 3'd2; bus.arburst = 2'b01; bus.arid = 4'd5;
    bus.awaddr = BASE + 32'h40; bus.awlen = 8'd0; bus.awsize = 3'd2; bus.awburst = 2'b01; bus.awid = 4'd6;
    bus.arvalid = 1'b1; bus.awvalid = 1'b1;
    check_eq("cc_arready", {31'd0, bus.arready}, 32'd1);
    check_eq("cc_awready", {31'd0, bus.awready}, 32'd1);
    @(posedge clk); #1;
    bus.arvalid = 1'b0; bus.awvalid = 1'b0;
    bus.wvalid = 1'b1; bus.wdata = 32'hCAFE_F00D; bus.wstrb = 4'hF; bus.wlast = 1'b1;
    bus.rready = 1'b1;
    e = rq.pop_front();
    check_eq("cc_rvalid", {31'd0, bus.rvalid}, 32'd1);
    check_eq("cc_wready", {31'd0, bus.wready}, 32'd1);
    check_eq("cc_rdata_old", bus.rdata, e.data);
    @(posedge clk); #1;
    bus.wvalid = 1'b0; bus.wlast = 1'b0; bus.rready = 1'b0;
    be = bq.pop_front();
    check_eq("cc_bvalid", {31'd0, bus.bvalid}, 32'd1);
    check_eq("cc_bresp", {30'd0, bus.bresp}, {30'd0, be.resp});
    check_eq("cc_bid", {28'd0, bus.bid}, {28'd0, be.id});
    bus.bready = 1'b1;
    @(posedge clk); #1;
    bus.bready = 1'b0;
    do_read("r_cc_new", BASE + 32'h40, 8'd0, 3'd2, 2'b01, 4'd5, -1, 0, 1'b0);

    // Reset in the middle of an 8-beat read
    bus.araddr = BASE; bus.arlen = 8'd7; bus.arsize = 3'd2; bus.arburst = 2'b01; bus.arid = 4'd9;
    bus.arvalid = 1'b1;
    check_eq("mr_arready", {31'd0, bus.arready}, 32'd1);
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    check_eq("mr_beat0", bus.rdata, mdl[0]);
    bus.rready = 1'b1;
    @(posedge clk); #1;
    check_eq("mr_beat1", bus.rdata, mdl[1]);
    @(posedge clk); #1;
    bus.rready = 1'b0;
    check_eq("mr_beat2_valid", {31'd0, bus.rvalid}, 32'd1);
    check_eq("mr_beat2_rid", {28'd0, bus.rid}, 32'd9);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_eq("mr_rvalid_after", {31'd0, bus.rvalid}, 32'd0);
    check_eq("mr_arready_after", {31'd0, bus.arready}, 32'd1);
    do_read("r_after_reset", BASE + 32'h10, 8'd1, 3'd2, 2'b01, 4'd10, -1, 0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
